// File: rtl/fp_exp_pkg.sv
// rtl/fp_exp_pkg.sv - float32 field widths, canonical constants and operand classes
package fp_exp_pkg;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_BIAS   = 127;

  localparam logic [31:0]         FP_QNAN    = 32'h7FC00000;
  localparam logic [FP_EXP_W-1:0] FP_INF_EXP = 8'hFF;

  typedef enum logic [2:0] {ZERO, NORM, SUBN, INF, NAN} fp_cls_e;
endpackage

// File: rtl/fp_exp_scale_if.sv
// rtl/fp_exp_scale_if.sv - operand/result handshake bundle for fp_exp_scale
interface fp_exp_scale_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_m;
  logic [9:0]  in_n;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_unf;

  modport master (
    output in_valid, in_m, in_n, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_m, in_n, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_unf
  );
endinterface

// File: rtl/fp_lzc24.sv
// rtl/fp_lzc24.sv - 24-bit leading-zero counter (24 when the input is zero)
module fp_lzc24 (
  input  logic [23:0] a,
  output logic [4:0]  cnt
);
  always_comb begin
    cnt = 5'd24;
    // Ascending scan: the highest set bit is the last to write cnt.
    for (int i = 0; i < 24; i++) begin
      if (a[i]) cnt = 5'(23 - i);
    end
  end
endmodule

// File: rtl/fp_exp_scale.sv
// rtl/fp_exp_scale.sv - float32 m * 2^n, 2-stage pipeline; FP_EXP_SUBNORM_EN enables subnormal in/out
module fp_exp_scale
  import fp_exp_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  fp_exp_scale_if.slave bus
);
  logic adv;

  logic                 s1_valid_q, s1_valid_d;
  fp_cls_e              s1_cls_q, s1_cls_d;
  logic                 s1_sign_q, s1_sign_d;
  logic [FP_FRAC_W-1:0] s1_frac_q, s1_frac_d;
  logic [11:0]          s1_exp_q, s1_exp_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_ovf_q, out_ovf_d;
  logic        out_unf_q, out_unf_d;

  logic [FP_EXP_W-1:0]  in_exp;
  logic [FP_FRAC_W-1:0] in_frac;
  logic [11:0]          n_ext;
  logic signed [11:0]   e2;
  logic [31:0]          res_data;
  logic                 res_ovf, res_unf;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv || RST;

  assign in_exp  = bus.in_m[30:23];
  assign in_frac = bus.in_m[22:0];
  assign n_ext   = {{2{bus.in_n[9]}}, bus.in_n};
  assign e2      = $signed(s1_exp_q);

`ifdef FP_EXP_SUBNORM_EN
  logic [4:0]  lzc;
  logic [23:0] sub_sig;
  logic [11:0] sh;
  logic [49:0] wide;
  logic [23:0] mant;
  logic        rnd;

  fp_lzc24 u_lzc (.a({1'b0, in_frac}), .cnt(lzc));
  assign sub_sig = {1'b0, in_frac} << lzc;
`endif

  // Stage 1: classify, exponent add, normalize subnormal operands.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cls_d   = s1_cls_q;
    s1_sign_d  = s1_sign_q;
    s1_frac_d  = s1_frac_q;
    s1_exp_d   = s1_exp_q;
    if (adv) begin
      s1_valid_d = bus.in_valid;
      s1_sign_d  = bus.in_m[31];
      s1_frac_d  = in_frac;
      s1_exp_d   = {4'b0, in_exp} + n_ext;
      if (in_exp == FP_INF_EXP) begin
        if (in_frac != '0) s1_cls_d = NAN;
        else               s1_cls_d = INF;
      end else if (in_exp != '0) begin
        s1_cls_d = NORM;
      end else if (in_frac == '0) begin
        s1_cls_d = ZERO;
      end else begin
`ifdef FP_EXP_SUBNORM_EN
        s1_cls_d  = SUBN;
        s1_frac_d = sub_sig[22:0];
        s1_exp_d  = 12'd1 - {7'b0, lzc} + n_ext;
`else
        s1_cls_d  = ZERO;
`endif
      end
    end
  end

  // Stage 2: saturate, denormalize with RNE, pack, flags.
  always_comb begin
    res_data = '0;
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
`ifdef FP_EXP_SUBNORM_EN
    sh   = '0;
    wide = '0;
    mant = '0;
    rnd  = 1'b0;
`endif
    case (s1_cls_q)
      NAN:  res_data = FP_QNAN;
      INF:  res_data = {s1_sign_q, FP_INF_EXP, 23'b0};
      ZERO: res_data = {s1_sign_q, 31'b0};
      default: begin
        if (e2 >= 12'sd255) begin
          res_data = {s1_sign_q, FP_INF_EXP, 23'b0};
          res_ovf  = 1'b1;
        end else if (e2 >= 12'sd1) begin
          res_data = {s1_sign_q, s1_exp_q[7:0], s1_frac_q};
        end else begin
          res_data = {s1_sign_q, 31'b0};
          res_unf  = 1'b1;
`ifdef FP_EXP_SUBNORM_EN
          sh = 12'd1 - s1_exp_q;
          // Beyond 25 the whole significand sits below guard: rounds to zero.
          if (sh <= 12'd25) begin
            wide = {1'b1, s1_frac_q, 26'b0} >> sh[4:0];
            rnd  = wide[25] & ((|wide[24:0]) | wide[26]);
            mant = wide[49:26] + {23'b0, rnd};
            // A carry into bit 23 lands in the exponent LSB: exponent field 1.
            res_data = {s1_sign_q, 7'b0, mant};
            res_unf  = wide[25] | (|wide[24:0]);
          end
`endif
        end
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_unf_d   = out_unf_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      out_data_d  = res_data;
      out_ovf_d   = res_ovf;
      out_unf_d   = res_unf;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q  <= 1'b0;
      s1_cls_q    <= ZERO;
      s1_sign_q   <= 1'b0;
      s1_frac_q   <= '0;
      s1_exp_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cls_q    <= s1_cls_d;
      s1_sign_q   <= s1_sign_d;
      s1_frac_q   <= s1_frac_d;
      s1_exp_q    <= s1_exp_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_unf_q   <= out_unf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_unf   = out_unf_q;
endmodule

// File: tb/tb_fp_exp_scale.sv
// tb/tb_fp_exp_scale.sv - directed self-checking bench for fp_exp_scale (FP_EXP_SUBNORM_EN aware)
module tb_fp_exp_scale;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  fp_exp_scale_if bus ();

  fp_exp_scale dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand for a single accepted cycle, then sample two edges later.
  task automatic run_vec(input logic [31:0] m, input logic [9:0] n,
                         output logic vld, output logic [31:0] d,
                         output logic ovf, output logic unf);
    bus.in_valid = 1'b1;
    bus.in_m     = m;
    bus.in_n     = n;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    vld = bus.out_valid;
    d   = bus.out_data;
    ovf = bus.out_ovf;
    unf = bus.out_unf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    n_cmp++;
    if (bus.out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data got=%h want=00000000", bus.out_data); end
    n_cmp++;
    if (bus.out_ovf !== 1'b0 || bus.out_unf !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags got ovf=%b unf=%b want 0/0", bus.out_ovf, bus.out_unf);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL post_reset got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_table(input string tag, input int cnt,
                            input logic [31:0] tm [8], input int tn [8],
                            input logic [31:0] td [8], input logic [1:0] tf [8]);
    logic vld, ovf, unf;
    logic [31:0] d;
    for (int i = 0; i < cnt; i++) begin
      run_vec(tm[i], 10'(tn[i]), vld, d, ovf, unf);
      n_cmp++;
      if (vld !== 1'b1 || d !== td[i] || {ovf, unf} !== tf[i]) begin
        n_bad++;
        $display("FAIL %s[%0d] m=%h n=%0d got v=%b d=%h ovf=%b unf=%b want v=1 d=%h ovf=%b unf=%b",
                 tag, i, tm[i], tn[i], vld, d, ovf, unf, td[i], tf[i][1], tf[i][0]);
      end
    end
  endtask

  task automatic test_normal();
    logic [31:0] tm [8];
    int          tn [8];
    logic [31:0] td [8];
    logic [1:0]  tf [8];
    tm = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'hBF800000, 32'h3F800000, 0, 0, 0};
    tn = '{3, 127, -1, -126, 127, 0, 0, 0};
    td = '{32'h41000000, 32'h7F400000, 32'h3F800000, 32'h80800000, 32'h7F000000, 0, 0, 0};
    tf = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    test_table("normal", 5, tm, tn, td, tf);
  endtask

  task automatic test_overflow();
    logic [31:0] tm [8];
    int          tn [8];
    logic [31:0] td [8];
    logic [1:0]  tf [8];
    tm = '{32'h3FC00000, 32'hBFC00000, 32'h7F7FFFFF, 32'h3F800000, 0, 0, 0, 0};
    tn = '{128, 200, 1, 511, 0, 0, 0, 0};
    td = '{32'h7F800000, 32'hFF800000, 32'h7F800000, 32'h7F800000, 0, 0, 0, 0};
    tf = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    test_table("overflow", 4, tm, tn, td, tf);
  endtask

  task automatic test_subnorm();
    logic [31:0] tm [8];
    int          tn [8];
    logic [31:0] td [8];
    logic [1:0]  tf [8];
    tm = '{32'h3FFFFFFF, 32'h3F800000, 32'h3F800000, 32'h3F800000,
           32'hBFC00000, 32'h00400000, 32'h3F800000, 32'h00000001};
    tn = '{-127, -127, -149, -150, -150, 2, -300, 0};
`ifdef FP_EXP_SUBNORM_EN
    td = '{32'h00800000, 32'h00400000, 32'h00000001, 32'h00000000,
           32'h80000001, 32'h01000000, 32'h00000000, 32'h00000001};
    tf = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
`else
    td = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
           32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000};
    tf = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
`endif
    test_table("subnorm", 8, tm, tn, td, tf);
  endtask

  task automatic test_special();
    logic [31:0] tm [8];
    int          tn [8];
    logic [31:0] td [8];
    logic [1:0]  tf [8];
    tm = '{32'h7FC00001, 32'hFFC00000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h00000000, 0, 0};
    tn = '{0, 3, 5, -300, 10, -512, 0, 0};
    td = '{32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h00000000, 0, 0};
    tf = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    test_table("special", 6, tm, tn, td, tf);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [5];
    int idx = 0;
    int got = 0;
    int cyc = 0;
    int extra = 0;
    exp_q = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h41000000, 32'h41800000};
    repeat (2) @(posedge clk);
    #1;
    while (got < 5 && cyc < 40) begin
      bus.out_ready = (cyc >= 4);
      bus.in_valid  = (idx < 5);
      bus.in_m      = 32'h3F800000;
      bus.in_n      = 10'(idx);
      #1;
      if (cyc == 1) begin
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_c1 got=%b want=1", bus.in_ready); end
      end
      if (cyc == 2) begin
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full got=%b want=0", bus.in_ready); end
      end
      if (cyc == 3) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h3F800000) begin
          n_bad++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=3f800000", bus.out_valid, bus.out_data);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (bus.out_data !== exp_q[got] || bus.out_ovf !== 1'b0 || bus.out_unf !== 1'b0) begin
          n_bad++; $display("FAIL bp_out[%0d] got=%h want=%h", got, bus.out_data, exp_q[got]);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (got != 5) begin n_bad++; $display("FAIL bp_count got=%0d want=5 (cycle budget)", got); end
    repeat (3) begin
      if (bus.out_valid === 1'b1) extra++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (extra != 0) begin n_bad++; $display("FAIL bp_no_extra got=%0d extra want=0", extra); end
  endtask

  task automatic test_reset_midstream();
    logic vld, ovf, unf;
    logic [31:0] d;
    int extra = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_m      = 32'h3F800000;
    bus.in_n      = 10'd0;
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_mid_fill got v=%b want=1", bus.out_valid); end
    rst = 1'b1;
    bus.in_m = 32'h40000000;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
      n_bad++; $display("FAIL rst_mid_clear got v=%b d=%h want v=0 d=00000000", bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1;
    repeat (4) begin
      if (bus.out_valid === 1'b1) extra++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (extra != 0) begin n_bad++; $display("FAIL rst_mid_drop got=%0d outputs want=0", extra); end
    run_vec(32'h3F800000, 10'd4, vld, d, ovf, unf);
    n_cmp++;
    if (vld !== 1'b1 || d !== 32'h41800000 || ovf !== 1'b0 || unf !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_recover got v=%b d=%h want v=1 d=41800000", vld, d);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_m      = 32'h0;
    bus.in_n      = 10'd0;
    bus.out_ready = 1'b1;
    test_reset();
    test_normal();
    test_overflow();
    test_subnorm();
    test_special();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
